// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester handshakes plus the memory-side bus of the unified memory port.
// The master side holds the requesters and the memory; the slave side is the arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic              cpu_byte;
  logic              cpu_lock;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;

  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_gnt;
  logic              disp_rvalid;

  logic              kbd_req;
  logic [ADDR_W-1:0] kbd_addr;
  logic [7:0]        kbd_wdata;
  logic              kbd_gnt;

  logic [31:0]       rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic              mem_byte;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport master (
    output cpu_req, cpu_we, cpu_byte, cpu_lock, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid,
    output disp_req, disp_addr,
    input  disp_gnt, disp_rvalid,
    output kbd_req, kbd_addr, kbd_wdata,
    input  kbd_gnt,
    input  rdata, mem_addr, mem_we, mem_byte, mem_wdata,
    output mem_rdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_byte, cpu_lock, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid,
    input  disp_req, disp_addr,
    output disp_gnt, disp_rvalid,
    input  kbd_req, kbd_addr, kbd_wdata,
    output kbd_gnt,
    output rdata, mem_addr, mem_we, mem_byte, mem_wdata,
    input  mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for CPU, display and keyboard with a CPU starvation guard,
// a CPU lock for atomic read-modify-write, and one-cycle registered read-valid return.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 8,
  parameter int ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);
  localparam int               CNT_W      = 8;
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= STARVE_MAX) ? STARVE_MAX : v + CNT_W'(1);
  endfunction

  logic             lock_q, lock_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             cpu_rvalid_q, cpu_rvalid_d;
  logic             disp_rvalid_q, disp_rvalid_d;

  logic             cpu_force;
  logic             gnt_cpu, gnt_disp, gnt_kbd;

  logic [ADDR_W-1:0] mem_addr_d;
  logic              mem_we_d;
  logic              mem_byte_d;
  logic [31:0]       mem_wdata_d;

  // Grant decision: lock or starvation lets the CPU jump the display > keyboard > CPU order.
  always_comb begin
    cpu_force = bus.cpu_req & (lock_q | (starve_cnt_q == STARVE_MAX));
  end

  always_comb begin
    gnt_cpu  = 1'b0;
    gnt_disp = 1'b0;
    gnt_kbd  = 1'b0;
    if (!reset) begin
      if (cpu_force)         gnt_cpu  = 1'b1;
      else if (bus.disp_req) gnt_disp = 1'b1;
      else if (bus.kbd_req)  gnt_kbd  = 1'b1;
      else if (bus.cpu_req)  gnt_cpu  = 1'b1;
    end
  end

  always_comb begin
    mem_addr_d  = '0;
    mem_we_d    = 1'b0;
    mem_byte_d  = 1'b0;
    mem_wdata_d = 32'h0;
    if (gnt_cpu) begin
      mem_addr_d  = bus.cpu_addr;
      mem_we_d    = bus.cpu_we;
      mem_byte_d  = bus.cpu_byte;
      mem_wdata_d = bus.cpu_wdata;
    end else if (gnt_disp) begin
      mem_addr_d  = bus.disp_addr;
    end else if (gnt_kbd) begin
      mem_addr_d  = bus.kbd_addr;
      mem_we_d    = 1'b1;
      mem_byte_d  = 1'b1;
      mem_wdata_d = {24'h0, bus.kbd_wdata};
    end
  end

  // Lock survives only while the CPU keeps requesting with cpu_lock held.
  always_comb begin
    lock_d = lock_q;
    if (gnt_cpu && bus.cpu_lock)             lock_d = 1'b1;
    else if (!bus.cpu_req || !bus.cpu_lock)  lock_d = 1'b0;

    starve_cnt_d = starve_cnt_q;
    if (gnt_cpu || !bus.cpu_req) starve_cnt_d = '0;
    else                         starve_cnt_d = sat_inc(starve_cnt_q);

    cpu_rvalid_d  = gnt_cpu & ~bus.cpu_we;
    disp_rvalid_d = gnt_disp;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_q        <= 1'b0;
      starve_cnt_q  <= '0;
      cpu_rvalid_q  <= 1'b0;
      disp_rvalid_q <= 1'b0;
    end else begin
      lock_q        <= lock_d;
      starve_cnt_q  <= starve_cnt_d;
      cpu_rvalid_q  <= cpu_rvalid_d;
      disp_rvalid_q <= disp_rvalid_d;
    end
  end

  assign bus.cpu_gnt     = gnt_cpu;
  assign bus.disp_gnt    = gnt_disp;
  assign bus.kbd_gnt     = gnt_kbd;
  assign bus.cpu_rvalid  = cpu_rvalid_q;
  assign bus.disp_rvalid = disp_rvalid_q;
  assign bus.rdata       = bus.mem_rdata;
  assign bus.mem_addr    = mem_addr_d;
  assign bus.mem_we      = mem_we_d;
  assign bus.mem_byte    = mem_byte_d;
  assign bus.mem_wdata   = mem_wdata_d;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small synchronous-read memory model.
module tb_mem_port_arbiter;
  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  mem_port_arbiter_if #(.ADDR_W(32)) bus ();

  mem_port_arbiter #(.STARVE_LIMIT(8), .ADDR_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:255];

  always @(posedge clk) begin
    if (bus.mem_we) begin
      if (bus.mem_byte)
        mem[bus.mem_addr[9:2]][bus.mem_addr[1:0]*8 +: 8] <= bus.mem_wdata[7:0];
      else
        mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
    end
    bus.mem_rdata <= mem[bus.mem_addr[9:2]];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] gnts();
    return {29'h0, bus.disp_gnt, bus.kbd_gnt, bus.cpu_gnt};
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[32'h40 >> 2]  = 32'hDEADBEEF;
    mem[32'h100 >> 2] = 32'h11112222;

    reset         = 1'b1;
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b0;
    bus.cpu_byte  = 1'b0;
    bus.cpu_lock  = 1'b0;
    bus.cpu_addr  = 32'h40;
    bus.cpu_wdata = 32'h0;
    bus.disp_req  = 1'b1;
    bus.disp_addr = 32'h40;
    bus.kbd_req   = 1'b1;
    bus.kbd_addr  = 32'h80;
    bus.kbd_wdata = 8'h5A;
    bus.mem_rdata = 32'h0;

    // Reset held three cycles with every request raised
    for (int k = 0; k < 3; k++) begin
      tick(); settle();
      chk("rst_gnt", gnts(), 32'h0);
      chk("rst_we", {31'h0, bus.mem_we}, 32'h0);
    end
    chk("rst_cpu_rvalid", {31'h0, bus.cpu_rvalid}, 32'h0);
    chk("rst_disp_rvalid", {31'h0, bus.disp_rvalid}, 32'h0);
    chk("rst_starve", {24'h0, dut.starve_cnt_q}, 32'h0);

    // Release: display, then keyboard, then CPU
    tick(); reset = 1'b0; settle();
    chk("prio_c0_gnt", gnts(), 32'h4);
    chk("prio_c0_addr", bus.mem_addr, 32'h40);
    tick(); bus.disp_req = 1'b0; settle();
    chk("prio_c1_dvalid", {31'h0, bus.disp_rvalid}, 32'h1);
    chk("prio_c1_rdata", bus.rdata, 32'hDEADBEEF);
    chk("prio_c1_gnt", gnts(), 32'h2);
    chk("prio_c1_wdata", bus.mem_wdata, 32'h0000005A);
    chk("prio_c1_byte", {31'h0, bus.mem_byte}, 32'h1);
    chk("prio_c1_we", {31'h0, bus.mem_we}, 32'h1);
    tick(); bus.kbd_req = 1'b0; settle();
    chk("prio_c2_gnt", gnts(), 32'h1);
    chk("prio_c2_we", {31'h0, bus.mem_we}, 32'h0);
    tick(); bus.cpu_req = 1'b0; settle();
    chk("prio_c3_cvalid", {31'h0, bus.cpu_rvalid}, 32'h1);
    chk("prio_c3_rdata", bus.rdata, 32'hDEADBEEF);
    chk("prio_c3_gnt", gnts(), 32'h0);
    chk("kbd_mem", mem[32'h80 >> 2], 32'h0000005A);

    // Starvation: display held, CPU wins on the ninth cycle
    tick();
    bus.disp_req  = 1'b1;
    bus.disp_addr = 32'h44;
    bus.cpu_req   = 1'b1;
    bus.cpu_addr  = 32'h40;
    for (int k = 0; k < 8; k++) begin
      settle();
      chk("starve_disp_gnt", gnts(), 32'h4);
      chk("starve_cnt", {24'h0, dut.starve_cnt_q}, 32'(k));
      tick();
    end
    settle();
    chk("starve_cpu_gnt", gnts(), 32'h1);
    chk("starve_sat", {24'h0, dut.starve_cnt_q}, 32'h8);
    tick(); bus.cpu_req = 1'b0; settle();
    chk("starve_resume", gnts(), 32'h4);
    chk("starve_clear", {24'h0, dut.starve_cnt_q}, 32'h0);
    chk("starve_cvalid", {31'h0, bus.cpu_rvalid}, 32'h1);

    // Lock: first CPU grant follows priority (via starvation), second is held by lock
    tick();
    bus.cpu_req  = 1'b1;
    bus.cpu_lock = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 32'h100;
    for (int k = 0; k < 8; k++) begin
      settle();
      chk("lock_wait_gnt", gnts(), 32'h4);
      tick();
    end
    settle();
    chk("lock_g1_gnt", gnts(), 32'h1);
    chk("lock_g1_addr", bus.mem_addr, 32'h100);
    tick();
    bus.cpu_we    = 1'b1;
    bus.cpu_lock  = 1'b0;
    bus.cpu_addr  = 32'h104;
    bus.cpu_wdata = 32'hCAFEF00D;
    settle();
    chk("lock_g2_gnt", gnts(), 32'h1);
    chk("lock_g2_we", {31'h0, bus.mem_we}, 32'h1);
    chk("lock_g2_cvalid", {31'h0, bus.cpu_rvalid}, 32'h1);
    chk("lock_g2_rdata", bus.rdata, 32'h11112222);
    tick(); bus.cpu_req = 1'b0; settle();
    chk("lock_after_gnt", gnts(), 32'h4);
    chk("lock_wr_novalid", {31'h0, bus.cpu_rvalid}, 32'h0);
    chk("lock_wr_mem", mem[32'h104 >> 2], 32'hCAFEF00D);

    // Write without return, then read back
    tick();
    bus.disp_req  = 1'b0;
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 32'h200;
    bus.cpu_wdata = 32'h12345678;
    settle();
    chk("wr_gnt", gnts(), 32'h1);
    chk("wr_we", {31'h0, bus.mem_we}, 32'h1);
    chk("wr_wdata", bus.mem_wdata, 32'h12345678);
    chk("wr_addr", bus.mem_addr, 32'h200);
    tick(); bus.cpu_we = 1'b0; settle();
    chk("wr_novalid", {31'h0, bus.cpu_rvalid}, 32'h0);
    chk("rd_gnt", gnts(), 32'h1);
    chk("rd_we", {31'h0, bus.mem_we}, 32'h0);
    tick(); bus.cpu_req = 1'b0; settle();
    chk("rd_cvalid", {31'h0, bus.cpu_rvalid}, 32'h1);
    chk("rd_rdata", bus.rdata, 32'h12345678);

    // Abandoned CPU request under a display grant
    tick();
    bus.disp_req  = 1'b1;
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 32'h300;
    bus.cpu_wdata = 32'hBAD0BAD0;
    settle();
    chk("abn_gnt", gnts(), 32'h4);
    chk("abn_we", {31'h0, bus.mem_we}, 32'h0);
    tick(); bus.cpu_req = 1'b0; settle();
    chk("abn_gnt2", gnts(), 32'h4);
    chk("abn_cnt1", {24'h0, dut.starve_cnt_q}, 32'h1);
    tick(); settle();
    chk("abn_cnt0", {24'h0, dut.starve_cnt_q}, 32'h0);
    chk("abn_mem", mem[32'h300 >> 2], 32'h0);

    // Reset during a lock: lock dropped, default priority afterwards
    tick();
    bus.disp_req = 1'b0;
    bus.cpu_req  = 1'b1;
    bus.cpu_lock = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 32'h100;
    settle();
    chk("rl_gnt", gnts(), 32'h1);
    tick(); reset = 1'b1; bus.disp_req = 1'b1; settle();
    chk("rl_rst_gnt", gnts(), 32'h0);
    chk("rl_rst_we", {31'h0, bus.mem_we}, 32'h0);
    tick(); reset = 1'b0; settle();
    chk("rl_post_gnt", gnts(), 32'h4);
    chk("rl_post_cvalid", {31'h0, bus.cpu_rvalid}, 32'h0);
    chk("rl_post_lock", {31'h0, dut.lock_q}, 32'h0);

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
